dpram_arbiter: RTL and testbench
================================

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width.
REQ-002 Parameter DATA_W, default 16, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cpu_cs  input  1  J1 I/O chip select for the RAM window.
REQ-006 cpu_rd  input  1  J1 read strobe; request = cpu_cs && (cpu_rd || cpu_wr).
REQ-007 cpu_wr  input  1  J1 write strobe.
REQ-008 cpu_addr  input  ADDR_W  J1 word address (8 LSB of the J1 io address).
REQ-009 cpu_din  input  DATA_W  J1 write data.
REQ-010 cpu_dout  output  DATA_W  last J1 read result.
REQ-011 cpu_ack  output  1  one-cycle completion pulse for the J1 access.
REQ-012 acq_req  input  1  acquisition-engine request, level.
REQ-013 acq_wr  input  1  1 = write, 0 = read.
REQ-014 acq_addr  input  ADDR_W  acquisition word address.
REQ-015 acq_din  input  DATA_W  acquisition write data (energy sample).
REQ-016 acq_dout  output  DATA_W  last acquisition read result.
REQ-017 acq_ack  output  1  one-cycle completion pulse for the acquisition access.
REQ-018 ram_addr  output  ADDR_W  to dualport_RAM addr.
REQ-019 ram_din  output  DATA_W  to dualport_RAM d_in.
REQ-020 ram_rd / ram_wr  output  1 each  to dualport_RAM rd / wr.
REQ-021 ram_dout  input  DATA_W  from dualport_RAM d_out, valid the cycle after ram_rd.
REQ-022 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-023 FSM states IDLE -> ACCESS -> CAPTURE -> ACK -> IDLE, one cycle each except IDLE; the only branch is in IDLE.
REQ-024 IDLE, no request: stay; one request: grant it; both: grant the requester not served last (last_gnt register, reset value ACQ, so the CPU wins the first tie).
REQ-025 On grant (IDLE exit edge), latch owner, address, write flag and write data; requester inputs are ignored until the next IDLE.
REQ-026 CPU with cpu_rd and cpu_wr both high: treat as write, no read.
REQ-027 ACCESS: ram_addr/ram_din driven from latches, exactly one of ram_rd/ram_wr high per latched write flag; both strobes low in every other state.
REQ-028 CAPTURE: for a read, load ram_dout into the owner's dout register at the end of the cycle; writes leave both dout registers unchanged.
REQ-029 ACK: assert the owner's ack for exactly one cycle; the other ack stays low; cpu_ack and acq_ack are never high together.
REQ-030 Latency: request seen in IDLE at cycle 0 -> ram strobe cycle 1 -> ack and valid dout cycle 3; one access per 4 cycles maximum.
REQ-031 Requesters hold their request until ack and drop it the cycle after ack; a request still high in the following IDLE is a new access.
REQ-032 Request withdrawn after grant: the access still completes and ack still pulses.
REQ-033 Fairness: under continuous contention grants strictly alternate; no requester waits more than one foreign access (≤ 7 cycles from request to its ack).
REQ-034 The dout registers hold their value between reads.

Reset
REQ-035 rst low: FSM -> IDLE immediately; ram_rd, ram_wr, cpu_ack, acq_ack, busy -> 0; ram_addr, ram_din, cpu_dout, acq_dout -> 0; last_gnt -> ACQ.
REQ-036 Reset during ACCESS/CAPTURE/ACK aborts the access with no ack; a write strobe already issued is not retracted.
REQ-037 After rst releases, the first possible grant occurs on the first rising edge with rst high.

Verification
REQ-038 CPU write 0x1234 @0x05 alone -> ram_wr=1, ram_addr=0x05, ram_din=0x1234 in cycle 1; cpu_ack in cycle 3; cpu_dout unchanged.
REQ-039 CPU read @0x05 after that write -> ram_rd in cycle 1, cpu_ack with cpu_dout=0x1234 in cycle 3.
REQ-040 cpu and acq requests both rising in the same cycle after reset -> CPU served first, then ACQ; acq_ack exactly 4 cycles after cpu_ack.
REQ-041 Both requests held continuously for 16 cycles -> acks alternate CPU, ACQ, CPU, ACQ; no back-to-back acks for one requester.
REQ-042 cpu_rd=cpu_wr=1 with data 0xBEEF @0x10 -> write only, ram_rd never high; a subsequent read @0x10 returns 0xBEEF.
REQ-043 rst low during CAPTURE of an acq read -> no acq_ack, acq_dout=0, busy=0; the next request is served normally with 4-cycle latency.

Source files
------------

// File: rtl/dpram_arbiter.sv
// rtl/dpram_arbiter.sv - two-requester (J1 CPU / acquisition) arbiter for a single-port RAM
// Four-cycle access FSM with alternating priority on contention.
module dpram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cs,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  input  logic              acq_req,
  input  logic              acq_wr,
  input  logic [ADDR_W-1:0] acq_addr,
  input  logic [DATA_W-1:0] acq_din,
  output logic [DATA_W-1:0] acq_dout,
  output logic              acq_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_rd,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_ACQ = 1'b1;

  state_t            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              own_q, own_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic [DATA_W-1:0] acq_dout_q, acq_dout_d;

  logic cpu_req;
  logic pick_cpu;

  assign cpu_req = cpu_cs && (cpu_rd || cpu_wr);
  // On a tie the requester that was not served last wins.
  assign pick_cpu = cpu_req && (!acq_req || (last_gnt_q == OWN_ACQ));

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    own_d      = own_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    din_d      = din_q;
    cpu_dout_d = cpu_dout_q;
    acq_dout_d = acq_dout_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || acq_req) begin
          state_d    = ACCESS;
          own_d      = pick_cpu ? OWN_CPU : OWN_ACQ;
          last_gnt_d = pick_cpu ? OWN_CPU : OWN_ACQ;
          addr_d     = pick_cpu ? cpu_addr : acq_addr;
          wr_d       = pick_cpu ? cpu_wr : acq_wr;
          din_d      = pick_cpu ? cpu_din : acq_din;
        end
      end
      ACCESS: state_d = CAPTURE;
      CAPTURE: begin
        state_d = ACK;
        if (!wr_q) begin
          if (own_q == OWN_CPU) cpu_dout_d = ram_dout;
          else                  acq_dout_d = ram_dout;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= OWN_ACQ;
      own_q      <= OWN_CPU;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      cpu_dout_q <= '0;
      acq_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      own_q      <= own_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      cpu_dout_q <= cpu_dout_d;
      acq_dout_q <= acq_dout_d;
    end
  end

  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign ram_rd   = (state_q == ACCESS) && !wr_q;
  assign ram_wr   = (state_q == ACCESS) && wr_q;
  assign cpu_ack  = (state_q == ACK) && (own_q == OWN_CPU);
  assign acq_ack  = (state_q == ACK) && (own_q == OWN_ACQ);
  assign busy     = (state_q != IDLE);
  assign cpu_dout = cpu_dout_q;
  assign acq_dout = acq_dout_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// tb/tb_dpram_arbiter.sv - directed, table-driven bench for dpram_arbiter
module tb_dpram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cs, cpu_rd, cpu_wr;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_din, cpu_dout;
  logic        cpu_ack;
  logic        acq_req, acq_wr;
  logic [7:0]  acq_addr;
  logic [15:0] acq_din, acq_dout;
  logic        acq_ack;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din, ram_dout;
  logic        ram_rd, ram_wr, busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    if (ram_rd) ram_dout <= mem[ram_addr];
  end

  dpram_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .acq_req(acq_req), .acq_wr(acq_wr), .acq_addr(acq_addr), .acq_din(acq_din),
    .acq_dout(acq_dout), .acq_ack(acq_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_dout(ram_dout), .busy(busy)
  );

  typedef struct {
    logic        cpu;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] din;
    logic        exp_rd;
    logic        exp_wr;
    logic [15:0] exp_dout;
    logic [15:0] exp_other;
  } vec_t;

  vec_t vecs [10];
  vec_t post_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    cpu_cs = 0; cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_din = 0;
    acq_req = 0; acq_wr = 0; acq_addr = 0; acq_din = 0;
  endtask

  // Caller is just after a rising edge with the DUT idle; returns in cycle 4, idle.
  task automatic apply(input vec_t v, input string tag);
    if (v.cpu) begin
      cpu_cs = 1; cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_din = v.din;
    end else begin
      acq_req = 1; acq_wr = v.wr; acq_addr = v.addr; acq_din = v.din;
    end
    @(negedge clk);
    check({tag, "_c0_busy"}, 32'(busy), 32'(0));
    @(negedge clk);
    check({tag, "_c1_rd"}, 32'(ram_rd), 32'(v.exp_rd));
    check({tag, "_c1_wr"}, 32'(ram_wr), 32'(v.exp_wr));
    check({tag, "_c1_addr"}, 32'(ram_addr), 32'(v.addr));
    if (v.exp_wr) check({tag, "_c1_din"}, 32'(ram_din), 32'(v.din));
    @(negedge clk);
    check({tag, "_c2_strobes"}, 32'({ram_rd, ram_wr}), 32'(0));
    @(negedge clk);
    check({tag, "_c3_ack"}, 32'({cpu_ack, acq_ack}), v.cpu ? 32'(2) : 32'(1));
    check({tag, "_c3_dout"}, v.cpu ? 32'(cpu_dout) : 32'(acq_dout), 32'(v.exp_dout));
    check({tag, "_c3_other"}, v.cpu ? 32'(acq_dout) : 32'(cpu_dout), 32'(v.exp_other));
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check({tag, "_c4_busy"}, 32'(busy), 32'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    int cpu_cyc, acq_cyc, cpu_n, acq_n;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 8'h05, 16'h1234, 1'b0, 1'b1, 16'h0000, 16'h6666};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h6666};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b1, 16'h1234, 16'h6666};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 16'h6666};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h20, 16'h00AA, 1'b0, 1'b1, 16'h6666, 16'hBEEF};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 1'b0, 16'h00AA, 16'hBEEF};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hBEEF};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 1'b0, 16'h00AA, 16'h1234};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b1, 16'h1234, 16'h00AA};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h00AA};
    post_rst = '{1'b0, 1'b1, 1'b0, 8'h31, 16'h0000, 1'b1, 1'b0, 16'h6666, 16'h0000};

    rst = 0;
    clear_inputs();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_strobes", 32'({ram_rd, ram_wr}), 32'(0));
    check("rst_acks", 32'({cpu_ack, acq_ack}), 32'(0));
    check("rst_ram_addr", 32'(ram_addr), 32'(0));
    check("rst_ram_din", 32'(ram_din), 32'(0));
    check("rst_cpu_dout", 32'(cpu_dout), 32'(0));
    check("rst_acq_dout", 32'(acq_dout), 32'(0));
    @(posedge clk); #1;

    // Tie straight out of reset: CPU first, ACQ four cycles later.
    rst = 1;
    cpu_cs = 1; cpu_wr = 1; cpu_addr = 8'h30; cpu_din = 16'h5555;
    acq_req = 1; acq_wr = 1; acq_addr = 8'h31; acq_din = 16'h6666;
    cpu_cyc = -1; acq_cyc = -1; cpu_n = 0; acq_n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      check("tie_excl", 32'(cpu_ack & acq_ack), 32'(0));
      if (cpu_ack) begin cpu_cyc = cyc; cpu_n++; end
      if (acq_ack) begin acq_cyc = cyc; acq_n++; end
      if (cyc == 1) check("tie_c1", 32'({ram_wr, ram_addr}), 32'({1'b1, 8'h30}));
      if (cyc == 5) check("tie_c5", 32'({ram_wr, ram_addr, ram_din}), 32'({1'b1, 8'h31, 16'h6666}));
      @(posedge clk); #1;
      if (cpu_n > 0) begin cpu_cs = 0; cpu_wr = 0; end
      if (acq_n > 0) begin acq_req = 0; acq_wr = 0; end
    end
    check("tie_cpu_cyc", 32'(cpu_cyc), 32'(3));
    check("tie_acq_cyc", 32'(acq_cyc), 32'(7));
    check("tie_cpu_n", 32'(cpu_n), 32'(1));
    check("tie_acq_n", 32'(acq_n), 32'(1));
    clear_inputs();

    // Continuous contention: grants alternate, starting with CPU.
    cpu_cs = 1; cpu_rd = 1; cpu_addr = 8'h30;
    acq_req = 1; acq_wr = 0; acq_addr = 8'h31;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      check($sformatf("cont_cpu_ack_c%0d", cyc), 32'(cpu_ack), 32'(cyc == 3 || cyc == 11));
      check($sformatf("cont_acq_ack_c%0d", cyc), 32'(acq_ack), 32'(cyc == 7 || cyc == 15));
      if (cyc == 3 || cyc == 11) check("cont_cpu_dout", 32'(cpu_dout), 32'(16'h5555));
      if (cyc == 7 || cyc == 15) check("cont_acq_dout", 32'(acq_dout), 32'(16'h6666));
      @(posedge clk); #1;
    end
    clear_inputs();

    // Strobes without chip select, and chip select without strobes, are not requests.
    cpu_cs = 0; cpu_rd = 1; cpu_wr = 1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("nocs_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    cpu_cs = 1; cpu_rd = 0; cpu_wr = 0;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("nostrobe_busy", 32'({busy, ram_rd, ram_wr}), 32'(0));
    @(posedge clk); #1;
    clear_inputs();

    // Reset during CAPTURE of an acquisition read.
    acq_req = 1; acq_wr = 0; acq_addr = 8'h31;
    @(negedge clk);
    @(negedge clk);
    check("abort_c1_rd", 32'(ram_rd), 32'(1));
    @(posedge clk); #1;
    rst = 0;
    acq_req = 0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_ack", 32'({cpu_ack, acq_ack}), 32'(0));
    check("abort_acq_dout", 32'(acq_dout), 32'(0));
    check("abort_cpu_dout", 32'(cpu_dout), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_no_late_ack", 32'(acq_ack), 32'(0));
    @(posedge clk); #1;
    rst = 1;
    apply(post_rst, "post_rst");

    for (int i = 0; i < 10; i++) apply(vecs[i], $sformatf("vec%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
